// File: rtl/pi_inject_arb.sv
// pi_inject_arb: round-robin injection scheduler for one pi-tree leaf port, with a one-entry
// stage that holds the granted packet until the link slot frees and flags prolonged starvation.
module pi_inject_arb #(
    parameter int N          = 8,
    parameter int A_W        = $clog2(N) + 1,
    parameter int D_W        = 32,
    parameter int R          = 4,
    parameter int R_W        = $clog2(R),
    parameter int STARVE_MAX = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [R-1:0]     req_v,
    input  logic [R*A_W-1:0] req_addr,
    input  logic [R*D_W-1:0] req_d,
    output logic [R-1:0]     req_rdy,
    input  logic             slot_busy,
    output logic             o_v,
    output logic [A_W-1:0]   o_addr,
    output logic [D_W-1:0]   o_d,
    output logic [R_W-1:0]   o_src,
    output logic             throttle,
    output logic [15:0]      inj_cnt
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] HOLD    = 2'd1;
    localparam logic [1:0] STARVED = 2'd2;
    logic [1:0]     state, state_nxt;
    logic [R_W-1:0] rr, sel, idx;
    logic [7:0]     sc, sc_inc;
    logic           found, stage_full, inject, blocked, can_load, transfer;
    assign stage_full = state != IDLE;
    assign inject     = ce & stage_full & ~slot_busy;
    assign blocked    = ce & stage_full & slot_busy;
    assign can_load   = ce & (~stage_full | inject);
    assign transfer   = can_load & found;
    assign o_v        = inject;
    assign throttle   = state == STARVED;
    assign req_rdy    = transfer ? (R'(1) << sel) : '0;
    assign sc_inc     = (sc == 8'hFF) ? sc : sc + 8'd1;
    // first active requester at or after rr, wrapping modulo R
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int k = 0; k < R; k++) begin
            idx = R_W'((int'(rr) + k) % R);
            if (!found && req_v[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end
    always_comb
        state_nxt = transfer ? HOLD :
                    inject   ? IDLE :
                    (blocked && int'(sc_inc) >= STARVE_MAX) ? STARVED : state;
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            o_addr  <= '0;
            o_d     <= '0;
            o_src   <= '0;
            rr      <= '0;
            sc      <= '0;
            inj_cnt <= '0;
        end else begin
            state <= state_nxt;
            sc    <= inject ? 8'd0 : blocked ? sc_inc : sc;
            if (inject) inj_cnt <= inj_cnt + 16'd1;
            if (transfer) begin
                o_addr <= req_addr[sel*A_W +: A_W];
                o_d    <= req_d[sel*D_W +: D_W];
                o_src  <= sel;
                rr     <= R_W'((int'(sel) + 1) % R);
            end
        end
    end
endmodule

// File: tb/tb_pi_inject_arb.sv
// tb_pi_inject_arb: scenario tasks plus randomized traffic checked against a
// cycle-level behavioural model of the injection scheduler.
module tb_pi_inject_arb;
    localparam int N = 8, A_W = $clog2(N) + 1, D_W = 32, R = 4, R_W = $clog2(R), SMAX = 15;
    logic clk = 1'b0, rst = 1'b1, ce = 1'b0, slot_busy = 1'b0;
    logic [R-1:0] req_v = '0, req_rdy;
    logic [R*A_W-1:0] req_addr = '0;
    logic [R*D_W-1:0] req_d = '0;
    logic o_v, throttle;
    logic [A_W-1:0] o_addr;
    logic [D_W-1:0] o_d;
    logic [R_W-1:0] o_src;
    logic [15:0] inj_cnt;
    int checks = 0, errors = 0;
    // model state
    bit m_full, m_thr, e_inj;
    logic [A_W-1:0] m_addr, pk_addr [R];
    logic [D_W-1:0] m_d, pk_d [R];
    int m_src, m_rr, m_sc, m_cnt, e_best;
    logic [R-1:0] e_rdy;

    pi_inject_arb #(.N(N), .A_W(A_W), .D_W(D_W), .R(R), .R_W(R_W), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst), .ce(ce), .req_v(req_v), .req_addr(req_addr), .req_d(req_d),
        .req_rdy(req_rdy), .slot_busy(slot_busy), .o_v(o_v), .o_addr(o_addr), .o_d(o_d),
        .o_src(o_src), .throttle(throttle), .inj_cnt(inj_cnt));

    always #5 clk = ~clk;

    task automatic set(input logic c, input logic [R-1:0] v, input logic b);
        int bd;
        ce = c; req_v = v; slot_busy = b;
        for (int i = 0; i < R; i++) begin
            req_addr[i*A_W +: A_W] = pk_addr[i];
            req_d[i*D_W +: D_W]    = pk_d[i];
        end
        e_inj = c && m_full && !b;
        e_best = -1; bd = R;
        for (int i = 0; i < R; i++)
            if (v[i] && ((i - m_rr + R) % R) < bd) begin bd = (i - m_rr + R) % R; e_best = i; end
        e_rdy = (c && (!m_full || e_inj) && e_best >= 0) ? (R'(1) << e_best) : '0;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) begin
            m_full = 0; m_thr = 0; m_addr = '0; m_d = '0; m_src = 0; m_rr = 0; m_sc = 0; m_cnt = 0;
        end else begin
            if (e_inj) begin
                m_cnt = (m_cnt + 1) % 65536; m_full = 0; m_sc = 0; m_thr = 0;
            end else if (ce && m_full && slot_busy) begin
                m_sc = (m_sc < 255) ? m_sc + 1 : 255;
                if (m_sc >= SMAX) m_thr = 1;
            end
            if (e_rdy != 0) begin
                m_full = 1; m_addr = pk_addr[e_best]; m_d = pk_d[e_best]; m_src = e_best;
                m_rr = (e_best + 1) % R;
                pk_addr[e_best] = A_W'($urandom); pk_d[e_best] = $urandom;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; set(0, '0, 0); step(); rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        set(0, '0, 0);
        checks++;
        if ({o_v, throttle, inj_cnt, o_addr, o_d, o_src} !== '0) begin
            errors++;
            $display("FAIL reset: o_v=%0b thr=%0b cnt=%0h addr=%0h d=%0h src=%0d required all 0",
                     o_v, throttle, inj_cnt, o_addr, o_d, o_src);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            set(1, 4'b1111, 0);
            checks++;
            if (req_rdy !== 4'(1 << (k % 4)) || o_v !== (k >= 1) ||
                (k >= 1 && o_src !== R_W'(k - 1))) begin
                errors++;
                $display("FAIL round_robin[%0d]: rdy=%b o_v=%b src=%0d", k, req_rdy, o_v, o_src);
            end
            step();
        end
    endtask

    task automatic test_skip();
        logic [R-1:0] want [3] = '{4'b0010, 4'b1000, 4'b0010};
        do_reset();
        for (int k = 0; k < 3; k++) begin
            set(1, 4'b1010, 0);
            checks++;
            if (req_rdy !== want[k]) begin
                errors++;
                $display("FAIL skip[%0d]: rdy=%b required %b", k, req_rdy, want[k]);
            end
            step();
        end
    endtask

    task automatic test_starve();
        logic [A_W-1:0] sa;
        logic [D_W-1:0] sd;
        do_reset();
        set(1, 4'b0001, 0); step();
        sa = m_addr; sd = m_d;
        for (int k = 0; k < 20; k++) begin
            set(1, 4'b1110, 1);
            checks++;
            if (req_rdy !== '0 || o_v !== 1'b0 || throttle !== (k >= SMAX)) begin
                errors++;
                $display("FAIL starve[%0d]: rdy=%b o_v=%b thr=%b required thr=%b",
                         k, req_rdy, o_v, throttle, k >= SMAX);
            end
            step();
        end
        set(1, 4'b1110, 0);
        checks++;
        if (o_v !== 1'b1 || o_addr !== sa || o_d !== sd || throttle !== 1'b1 || req_rdy !== 4'b0010) begin
            errors++;
            $display("FAIL starve_release: o_v=%b addr=%0h/%0h d=%0h/%0h thr=%b rdy=%b",
                     o_v, o_addr, sa, o_d, sd, throttle, req_rdy);
        end
        step();
        for (int k = 0; k < 16; k++) begin
            set(1, 4'b0000, 1);
            checks++;
            if (throttle !== (k == 15) || o_src !== R_W'(1)) begin
                errors++;
                $display("FAIL starve_restart[%0d]: thr=%b src=%0d", k, throttle, o_src);
            end
            step();
        end
    endtask

    task automatic test_pass_through();
        do_reset();
        set(1, 4'b0001, 0); step();
        set(1, 4'b0100, 0);
        checks++;
        if (o_v !== 1'b1 || req_rdy !== 4'b0100 || o_src !== R_W'(0)) begin
            errors++;
            $display("FAIL pass_through_a: o_v=%b rdy=%b src=%0d", o_v, req_rdy, o_src);
        end
        step();
        set(1, 4'b0000, 0);
        checks++;
        if (o_v !== 1'b1 || o_src !== R_W'(2) || inj_cnt !== 16'd1) begin
            errors++;
            $display("FAIL pass_through_b: o_v=%b src=%0d cnt=%0d", o_v, o_src, inj_cnt);
        end
        step();
    endtask

    task automatic test_ce();
        do_reset();
        set(1, 4'b0001, 0); step();
        for (int k = 0; k < 3; k++) begin
            set(0, 4'b1111, 0);
            checks++;
            if (o_v !== 1'b0 || req_rdy !== '0 || inj_cnt !== 16'd0) begin
                errors++;
                $display("FAIL ce_hold[%0d]: o_v=%b rdy=%b cnt=%0d", k, o_v, req_rdy, inj_cnt);
            end
            step();
        end
        set(1, 4'b0000, 0);
        checks++;
        if (o_v !== 1'b1) begin errors++; $display("FAIL ce_resume: o_v=%b required 1", o_v); end
        step();
        set(1, 4'b0000, 0);
        checks++;
        if (inj_cnt !== 16'd1 || o_v !== 1'b0) begin
            errors++;
            $display("FAIL ce_count: cnt=%0d o_v=%b required 1/0", inj_cnt, o_v);
        end
        step();
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            set($urandom_range(0, 7) != 0, R'($urandom), $urandom_range(0, 2) == 0);
            checks++;
            if (req_rdy !== e_rdy || o_v !== e_inj || o_addr !== m_addr || o_d !== m_d ||
                o_src !== R_W'(m_src) || throttle !== m_thr || inj_cnt !== 16'(m_cnt)) begin
                errors++;
                $display("FAIL random[%0d]: rdy=%b/%b o_v=%b/%b addr=%0h/%0h d=%0h/%0h src=%0d/%0d thr=%b/%b cnt=%0d/%0d",
                         k, req_rdy, e_rdy, o_v, e_inj, o_addr, m_addr, o_d, m_d, o_src, m_src,
                         throttle, m_thr, inj_cnt, m_cnt);
            end
            step();
        end
    endtask

    task automatic test_reset_wrap();
        do_reset();
        set(1, 4'b0100, 0); step();
        for (int k = 0; k < 16; k++) begin set(1, 4'b0000, 1); step(); end
        set(1, 4'b0000, 1);
        checks++;
        if (throttle !== 1'b1) begin errors++; $display("FAIL starved_pre: thr=%b required 1", throttle); end
        rst = 1'b1; step(); rst = 1'b0;
        set(1, 4'b1111, 0);
        checks++;
        if (o_v !== 1'b0 || throttle !== 1'b0 || inj_cnt !== 16'd0 || req_rdy !== 4'b0001) begin
            errors++;
            $display("FAIL starved_reset: o_v=%b thr=%b cnt=%0d rdy=%b", o_v, throttle, inj_cnt, req_rdy);
        end
        step();
        for (int k = 0; k < 70000 && m_cnt != 65535; k++) begin set(1, 4'b1111, 0); step(); end
        set(1, 4'b1111, 0);
        checks++;
        if (inj_cnt !== 16'hFFFF || o_v !== 1'b1) begin
            errors++;
            $display("FAIL wrap_pre: cnt=%0h o_v=%b required ffff/1", inj_cnt, o_v);
        end
        step();
        set(1, 4'b0000, 0);
        checks++;
        if (inj_cnt !== 16'h0000) begin errors++; $display("FAIL wrap: cnt=%0h required 0", inj_cnt); end
        step();
    endtask

    initial begin
        for (int i = 0; i < R; i++) begin pk_addr[i] = A_W'($urandom); pk_d[i] = $urandom; end
        @(negedge clk);
        test_reset();
        test_round_robin();
        test_skip();
        test_starve();
        test_pass_through();
        test_ce();
        test_random();
        test_reset_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
